// File: rtl/banked_data_mem.sv
// rtl/banked_data_mem.sv - byte-lane data memory with valid/ready requests and split misaligned accesses
// Misaligned accesses run phase 1 on word W and phase 2 on word W+1, merging read bytes before the response.
module banked_data_mem #(
  parameter int LANES      = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 8192,
  parameter int RD_LATENCY = 1,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_wr,
  input  logic [1:0]            req_size,
  input  logic [8*LANES-1:0]    req_wdata,
  output logic                  rsp_valid,
  output logic [8*LANES-1:0]    rsp_rdata
);
  localparam int LOG_LANES = $clog2(LANES);
  localparam int IDX_W     = $clog2(DEPTH);
  localparam int DW        = 8 * LANES;

  typedef enum logic {IDLE, SPLIT} state_t;
  state_t state, state_nxt;

  logic [DW-1:0]        mem [DEPTH];

  logic                 accept;
  logic [LOG_LANES-1:0] off;
  logic [1:0]           size_eff;
  logic [IDX_W-1:0]     idx;
  logic                 misaligned;
  logic [LANES-1:0]     lane_en, en_hi, en_lo;
  logic [DW-1:0]        wrot;

  logic [IDX_W-1:0]     mem_idx;
  logic [LANES-1:0]     mem_we;
  logic [DW-1:0]        mem_wd;
  logic [DW-1:0]        rd_word, p1_word;

  logic [IDX_W-1:0]     sp_idx;
  logic [DW-1:0]        sp_wdata;
  logic [LANES-1:0]     sp_en;
  logic                 sp_wr;
  logic [LOG_LANES-1:0] m_off;
  logic [1:0]           m_size;
  logic                 m_wr, m_split, s1_valid;
  logic [DW-1:0]        merged, assembled, rdata1;

  assign accept = req_valid && req_ready;

  // Request decode: lane k of the word carries request byte (k - offset) mod LANES.
  always_comb begin
    size_eff   = (int'(req_size) > LOG_LANES) ? 2'(LOG_LANES) : req_size;
    off        = req_addr[LOG_LANES-1:0];
    idx        = IDX_W'(req_addr >> LOG_LANES);
    misaligned = (int'(off) + (1 << size_eff)) > LANES;
    lane_en    = '0;
    en_hi      = '0;
    en_lo      = '0;
    wrot       = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_en[l]       = ((l - int'(off)) & (LANES - 1)) < (1 << size_eff);
      wrot[8*l +: 8]   = req_wdata[8*((l - int'(off)) & (LANES - 1)) +: 8];
      en_hi[l]         = lane_en[l] && (l >= int'(off));
      en_lo[l]         = lane_en[l] && (l < int'(off));
    end
  end

  always_comb begin
    mem_idx = idx;
    mem_wd  = wrot;
    mem_we  = '0;
    if (state == SPLIT) begin
      mem_idx = sp_idx;
      mem_wd  = sp_wdata;
      if (sp_wr) mem_we = sp_en;
    end else if (accept && req_wr) begin
      mem_we = en_hi;
    end
  end

  // Array port: registered read sees the word before this edge's write.
  always_ff @(posedge clk) begin
    rd_word <= mem[mem_idx];
    for (int l = 0; l < LANES; l++) begin
      if (mem_we[l]) mem[mem_idx][8*l +: 8] <= mem_wd[8*l +: 8];
    end
    if (state == SPLIT) p1_word <= rd_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_idx   <= '0;
      sp_wdata <= '0;
      sp_en    <= '0;
      sp_wr    <= 1'b0;
      m_off    <= '0;
      m_size   <= '0;
      m_wr     <= 1'b0;
      m_split  <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= 1'b0;
      if (accept) begin
        sp_idx   <= idx + 1'b1;
        sp_wdata <= wrot;
        sp_en    <= en_lo;
        sp_wr    <= req_wr;
        m_off    <= off;
        m_size   <= size_eff;
        m_wr     <= req_wr;
        m_split  <= misaligned;
        s1_valid <= !misaligned;
      end else if (state == SPLIT) begin
        s1_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    merged    = '0;
    assembled = '0;
    for (int l = 0; l < LANES; l++) begin
      merged[8*l +: 8] = (m_split && l >= int'(m_off)) ? p1_word[8*l +: 8] : rd_word[8*l +: 8];
    end
    for (int k = 0; k < LANES; k++) begin
      if (k < (1 << m_size)) assembled[8*k +: 8] = merged[8*((k + int'(m_off)) & (LANES - 1)) +: 8];
    end
    rdata1 = (s1_valid && !m_wr) ? assembled : '0;
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic          q_valid;
      logic [DW-1:0] q_data;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q_valid <= 1'b0;
          q_data  <= '0;
        end else begin
          q_valid <= s1_valid;
          q_data  <= rdata1;
        end
      end
      assign rsp_valid = q_valid;
      assign rsp_rdata = q_data;
    end else begin : g_lat1
      assign rsp_valid = s1_valid;
      assign rsp_rdata = rdata1;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && misaligned) state_nxt = SPLIT;
      SPLIT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
  end
endmodule

// File: tb/tb_banked_data_mem.sv
// tb/tb_banked_data_mem.sv - directed bench for banked_data_mem
// Instance a: LANES=2, RD_LATENCY=1. Instance b: LANES=4, RD_LATENCY=2.
module tb_banked_data_mem;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic        a_valid = 1'b0, a_ready, a_wr = 1'b0, a_rvalid;
  logic [15:0] a_addr = '0, a_wdata = '0, a_rdata;
  logic [1:0]  a_size = '0;
  logic        b_valid = 1'b0, b_ready, b_wr = 1'b0, b_rvalid;
  logic [15:0] b_addr = '0;
  logic [31:0] b_wdata = '0, b_rdata;
  logic [1:0]  b_size = '0;

  always #5 clk = ~clk;

  banked_data_mem #(.LANES(2), .ADDR_WIDTH(16), .DEPTH(8192), .RD_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_addr(a_addr),
    .req_wr(a_wr), .req_size(a_size), .req_wdata(a_wdata), .rsp_valid(a_rvalid), .rsp_rdata(a_rdata));

  banked_data_mem #(.LANES(4), .ADDR_WIDTH(16), .DEPTH(8192), .RD_LATENCY(2)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_addr(b_addr),
    .req_wr(b_wr), .req_size(b_size), .req_wdata(b_wdata), .rsp_valid(b_rvalid), .rsp_rdata(b_rdata));

  task automatic a_issue(input logic wr, input logic [15:0] addr, input logic [1:0] size, input logic [15:0] wd);
    a_valid = 1'b1; a_wr = wr; a_addr = addr; a_size = size; a_wdata = wd;
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic a_wait(output int lat, output logic [15:0] data);
    lat = 0;
    while (a_rvalid !== 1'b1 && lat < 8) begin @(posedge clk); #1; lat++; end
    data = a_rdata;
    if (lat < 8) begin @(posedge clk); #1; end
  endtask

  task automatic b_issue(input logic wr, input logic [15:0] addr, input logic [1:0] size, input logic [31:0] wd);
    b_valid = 1'b1; b_wr = wr; b_addr = addr; b_size = size; b_wdata = wd;
    @(posedge clk); #1;
    b_valid = 1'b0;
  endtask

  task automatic b_wait(output int lat, output logic [31:0] data);
    lat = 0;
    while (b_rvalid !== 1'b1 && lat < 8) begin @(posedge clk); #1; lat++; end
    data = b_rdata;
    if (lat < 8) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL reset_a_ready got=%b exp=1", a_ready); end
    checks++; if (a_rvalid !== 1'b0) begin failures++; $display("FAIL reset_a_rvalid got=%b exp=0", a_rvalid); end
    checks++; if (a_rdata !== 16'h0) begin failures++; $display("FAIL reset_a_rdata got=%h exp=0", a_rdata); end
    checks++; if (b_rvalid !== 1'b0 || b_rdata !== 32'h0) begin failures++; $display("FAIL reset_b_rsp got=%b/%h exp=0/0", b_rvalid, b_rdata); end
  endtask

  task automatic test_aligned;
    int lat; logic [15:0] d;
    a_issue(1'b1, 16'h0010, 2'd1, 16'hBEEF); a_wait(lat, d);
    checks++; if (lat !== 0 || d !== 16'h0) begin failures++; $display("FAIL wr_rsp lat=%0d data=%h exp lat=0 data=0", lat, d); end
    a_issue(1'b0, 16'h0010, 2'd1, 16'h0); a_wait(lat, d);
    checks++; if (lat !== 0) begin failures++; $display("FAIL rd_latency got=%0d exp=0", lat); end
    checks++; if (d !== 16'hBEEF) begin failures++; $display("FAIL rd_beef got=%h exp=beef", d); end
  endtask

  task automatic test_byte_lane;
    int lat; logic [15:0] d;
    a_issue(1'b1, 16'h0011, 2'd0, 16'h005A); a_wait(lat, d);
    a_issue(1'b0, 16'h0010, 2'd1, 16'h0); a_wait(lat, d);
    checks++; if (d !== 16'h5AEF) begin failures++; $display("FAIL byte_merge got=%h exp=5aef", d); end
    a_issue(1'b0, 16'h0011, 2'd0, 16'h0); a_wait(lat, d);
    checks++; if (d !== 16'h005A) begin failures++; $display("FAIL byte_zext got=%h exp=005a", d); end
    a_issue(1'b0, 16'h0010, 2'd3, 16'h0); a_wait(lat, d);
    checks++; if (lat !== 0 || d !== 16'h5AEF) begin failures++; $display("FAIL size_clamp lat=%0d data=%h exp lat=0 data=5aef", lat, d); end
  endtask

  task automatic test_misaligned;
    int lat; logic [15:0] d;
    a_issue(1'b1, 16'h0020, 2'd0, 16'h0077); a_wait(lat, d);
    a_issue(1'b1, 16'h0021, 2'd1, 16'h1234);
    checks++; if (a_ready !== 1'b0 || a_rvalid !== 1'b0) begin failures++; $display("FAIL split_cycle ready=%b rvalid=%b exp 0/0", a_ready, a_rvalid); end
    @(posedge clk); #1;
    checks++; if (a_ready !== 1'b1 || a_rvalid !== 1'b1 || a_rdata !== 16'h0) begin failures++; $display("FAIL split_done ready=%b rvalid=%b data=%h exp 1/1/0", a_ready, a_rvalid, a_rdata); end
    @(posedge clk); #1;
    a_issue(1'b0, 16'h0021, 2'd1, 16'h0); a_wait(lat, d);
    checks++; if (lat !== 1 || d !== 16'h1234) begin failures++; $display("FAIL mis_read lat=%0d data=%h exp lat=1 data=1234", lat, d); end
    a_issue(1'b0, 16'h0020, 2'd0, 16'h0); a_wait(lat, d);
    checks++; if (d !== 16'h0077) begin failures++; $display("FAIL mis_lane0_kept got=%h exp=0077", d); end
    a_issue(1'b0, 16'h0021, 2'd0, 16'h0); a_wait(lat, d);
    checks++; if (d !== 16'h0034) begin failures++; $display("FAIL mis_phase1 got=%h exp=0034", d); end
    a_issue(1'b0, 16'h0022, 2'd0, 16'h0); a_wait(lat, d);
    checks++; if (d !== 16'h0012) begin failures++; $display("FAIL mis_phase2 got=%h exp=0012", d); end
  endtask

  task automatic test_wrap;
    int lat; logic [15:0] d;
    a_issue(1'b1, 16'hFFFF, 2'd1, 16'h55AA); a_wait(lat, d);
    checks++; if (lat !== 1) begin failures++; $display("FAIL wrap_wr_lat got=%0d exp=1", lat); end
    a_issue(1'b0, 16'h3FFF, 2'd0, 16'h0); a_wait(lat, d);
    checks++; if (d !== 16'h00AA) begin failures++; $display("FAIL wrap_word1fff got=%h exp=00aa", d); end
    a_issue(1'b0, 16'h0000, 2'd0, 16'h0); a_wait(lat, d);
    checks++; if (d !== 16'h0055) begin failures++; $display("FAIL wrap_word0 got=%h exp=0055", d); end
    a_issue(1'b0, 16'hFFFF, 2'd1, 16'h0); a_wait(lat, d);
    checks++; if (lat !== 1 || d !== 16'h55AA) begin failures++; $display("FAIL wrap_read lat=%0d data=%h exp lat=1 data=55aa", lat, d); end
  endtask

  task automatic test_read_after_write;
    a_valid = 1'b1; a_wr = 1'b1; a_addr = 16'h0040; a_size = 2'd1; a_wdata = 16'hC0DE;
    @(posedge clk); #1;
    a_wr = 1'b0;
    checks++; if (a_rvalid !== 1'b1 || a_rdata !== 16'h0) begin failures++; $display("FAIL raw_wr_rsp rvalid=%b data=%h exp 1/0", a_rvalid, a_rdata); end
    @(posedge clk); #1;
    a_valid = 1'b0;
    checks++; if (a_rvalid !== 1'b1 || a_rdata !== 16'hC0DE) begin failures++; $display("FAIL raw_rd rvalid=%b data=%h exp 1/c0de", a_rvalid, a_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] d;
    b_issue(1'b1, 16'h0100, 2'd2, 32'h11223344); b_wait(lat, d);
    checks++; if (lat !== 1 || d !== 32'h0) begin failures++; $display("FAIL b_wr_rsp lat=%0d data=%h exp lat=1 data=0", lat, d); end
    b_issue(1'b1, 16'h0104, 2'd2, 32'h55667788); b_wait(lat, d);
    b_issue(1'b1, 16'h0108, 2'd2, 32'h99AABBCC); b_wait(lat, d);
    b_valid = 1'b1; b_wr = 1'b0; b_addr = 16'h0100; b_size = 2'd3;
    @(posedge clk); #1;
    checks++; if (b_rvalid !== 1'b0) begin failures++; $display("FAIL b2b_early got=%b exp=0", b_rvalid); end
    b_addr = 16'h0104; b_size = 2'd2;
    @(posedge clk); #1;
    checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'h11223344) begin failures++; $display("FAIL b2b_first rvalid=%b data=%h exp 1/11223344", b_rvalid, b_rdata); end
    b_addr = 16'h010A; b_size = 2'd1;
    @(posedge clk); #1;
    b_valid = 1'b0;
    checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'h55667788) begin failures++; $display("FAIL b2b_second rvalid=%b data=%h exp 1/55667788", b_rvalid, b_rdata); end
    @(posedge clk); #1;
    checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'h000099AA) begin failures++; $display("FAIL b2b_third rvalid=%b data=%h exp 1/000099aa", b_rvalid, b_rdata); end
    @(posedge clk); #1;
    checks++; if (b_rvalid !== 1'b0) begin failures++; $display("FAIL b2b_tail got=%b exp=0", b_rvalid); end
    b_issue(1'b0, 16'h0103, 2'd1, 32'h0);
    checks++; if (b_ready !== 1'b0) begin failures++; $display("FAIL b_split_ready got=%b exp=0", b_ready); end
    b_wait(lat, d);
    checks++; if (lat !== 2 || d !== 32'h00008811) begin failures++; $display("FAIL b_mis_read lat=%0d data=%h exp lat=2 data=00008811", lat, d); end
  endtask

  task automatic test_reset_split;
    int lat; int seen; logic [15:0] d;
    a_issue(1'b1, 16'h0060, 2'd1, 16'h1111); a_wait(lat, d);
    a_issue(1'b1, 16'h0062, 2'd1, 16'h2222); a_wait(lat, d);
    a_issue(1'b1, 16'h0061, 2'd1, 16'hABCD);
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL rs_in_split got=%b exp=0", a_ready); end
    rst = 1'b1; #1;
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL rs_ready_async got=%b exp=1", a_ready); end
    seen = 0;
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (a_rvalid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL rs_no_rsp got=%0d strobes exp=0", seen); end
    a_issue(1'b0, 16'h0060, 2'd1, 16'h0); a_wait(lat, d);
    checks++; if (d !== 16'hCD11) begin failures++; $display("FAIL rs_phase1_kept got=%h exp=cd11", d); end
    a_issue(1'b0, 16'h0062, 2'd1, 16'h0); a_wait(lat, d);
    checks++; if (d !== 16'h2222) begin failures++; $display("FAIL rs_phase2_skipped got=%h exp=2222", d); end
  endtask

  task automatic test_reset_pending;
    int seen;
    b_issue(1'b0, 16'h0100, 2'd2, 32'h0);
    rst = 1'b1; #1;
    checks++; if (b_rvalid !== 1'b0) begin failures++; $display("FAIL rp_rvalid got=%b exp=0", b_rvalid); end
    seen = 0;
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (b_rvalid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL rp_dropped got=%0d strobes exp=0", seen); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_aligned();
    test_byte_lane();
    test_misaligned();
    test_wrap();
    test_read_after_write();
    test_back_to_back();
    test_reset_split();
    test_reset_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
